rf_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (we/rd/wd) between two writeback

---
 rtl/rf_wb_arbiter_if.sv | 14 +
 rtl/rf_wb_arbiter.sv | 108 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request channel: one requester (ALU or LSU) presenting a register write.
// The master drives the request; the arbiter (slave) answers with ready.
interface rf_wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            valid;
  logic            ready;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] wd;

  modport master (output valid, rd, wd, input ready);
  modport slave  (input valid, rd, wd, output ready);
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter (ALU vs LSU) with a busy scoreboard for decode hazards.
// Optional RF_WB_BYPASS_EN adds forwarding of the registered write data to decode.
module rf_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst,
  rf_wb_arbiter_if.slave  alu,
  rf_wb_arbiter_if.slave  lsu,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
`ifdef RF_WB_BYPASS_EN
  output logic            rs1_fwd_val,
  output logic            rs2_fwd_val,
  output logic [XLEN-1:0] rs1_fwd_wd,
  output logic [XLEN-1:0] rs2_fwd_wd,
`endif
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wd
);

  localparam int NREG = 1 << AW;
  localparam int SW   = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic [SW-1:0]   starve_cnt;
  logic            alu_win;
  logic            grant;
  logic [AW-1:0]   g_rd;
  logic [XLEN-1:0] g_wd;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_n;
  logic            rs1_pend;
  logic            rs2_pend;

  // Handshake: a request transfers in the cycle valid && ready are both high.
  // ready is a pure function of both valids and the starvation counter, never of
  // the requester's own ready, and at most one of alu.ready / lsu.ready is high.
  assign alu_win   = alu.valid && (!lsu.valid || (starve_cnt == STARVE_TOP));
  assign alu.ready = alu_win;
  assign lsu.ready = lsu.valid && !alu_win;
  assign grant     = alu.ready || lsu.ready;
  assign g_rd      = alu_win ? alu.rd : lsu.rd;
  assign g_wd      = alu_win ? alu.wd : lsu.wd;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!alu.valid || alu_win) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_TOP) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Writes to x0 complete the handshake but never raise rf_we.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= grant && (g_rd != '0);
      if (grant) begin
        rf_rd <= g_rd;
        rf_wd <= g_wd;
      end
    end
  end

  assign issue_ready = (issue_rd == '0) || !busy_q[issue_rd];

  // Clear lands on the same edge the regfile commits; set and clear never hit one index.
  always_comb begin
    busy_n = busy_q;
    if (rf_we) busy_n[rf_rd] = 1'b0;
    if (issue_valid && issue_ready && (issue_rd != '0)) busy_n[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_n;
  end

  assign rs1_pend = (rs1 != '0) && busy_q[rs1];
  assign rs2_pend = (rs2 != '0) && busy_q[rs2];

`ifdef RF_WB_BYPASS_EN
  assign rs1_fwd_val = rf_we && (rf_rd == rs1) && (rs1 != '0);
  assign rs2_fwd_val = rf_we && (rf_rd == rs2) && (rs2 != '0);
  assign rs1_fwd_wd  = rs1_fwd_val ? rf_wd : '0;
  assign rs2_fwd_wd  = rs2_fwd_val ? rf_wd : '0;
  assign rs1_busy    = rs1_pend && !rs1_fwd_val;
  assign rs2_busy    = rs2_pend && !rs2_fwd_val;
`else
  assign rs1_busy    = rs1_pend;
  assign rs2_busy    = rs2_pend;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: arbitration vector table plus hand-written scoreboard,
// x0 and reset sequences; writeback expectations flow through a timed queue.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
`ifdef RF_WB_BYPASS_EN
  logic        rs1_fwd_val, rs2_fwd_val;
  logic [31:0] rs1_fwd_wd, rs2_fwd_wd;
`endif

  rf_wb_arbiter_if #(.XLEN(32), .AW(5)) alu_if ();
  rf_wb_arbiter_if #(.XLEN(32), .AW(5)) lsu_if ();

  rf_wb_arbiter #(.XLEN(32), .AW(5), .STARVE_MAX(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu         (alu_if),
    .lsu         (lsu_if),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
`ifdef RF_WB_BYPASS_EN
    .rs1_fwd_val (rs1_fwd_val),
    .rs2_fwd_val (rs2_fwd_val),
    .rs1_fwd_wd  (rs1_fwd_wd),
    .rs2_fwd_wd  (rs2_fwd_wd),
`endif
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_wd       (rf_wd)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // scoreboard entry: {due cycle[15:0], rd[4:0], wd[31:0]}
  logic [52:0] exp_q[$];

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] awd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] lwd;
    logic        e_ar;
    logic        e_lr;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
                              input logic e_ar, input logic e_lr);
    vec_t v;
    v.av = av; v.ard = ard; v.awd = awd;
    v.lv = lv; v.lrd = lrd; v.lwd = lwd;
    v.e_ar = e_ar; v.e_lr = e_lr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] lwd);
    alu_if.valid = av; alu_if.rd = ard; alu_if.wd = awd;
    lsu_if.valid = lv; lsu_if.rd = lrd; lsu_if.wd = lwd;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] wd);
    logic [15:0] due;
    due = 16'(cyc + 1);
    if (rd != 5'd0) exp_q.push_back({due, rd, wd});
  endtask

  // Called once per cycle at the negedge: writeback port versus the queue head.
  task automatic check_wb();
    logic [52:0] e;
    if (exp_q.size() > 0 && exp_q[0][52:37] == 16'(cyc)) begin
      e = exp_q.pop_front();
      chk("wb_we", 32'(rf_we), 32'd1);
      chk("wb_rd", 32'(rf_rd), 32'(e[36:32]));
      chk("wb_wd", rf_wd, e[31:0]);
    end else begin
      chk("wb_idle_we", 32'(rf_we), 32'd0);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    check_wb();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    // reset state
    rs1 = 5'd1; rs2 = 5'd31; issue_rd = 5'd1;
    settle();
    chk("rst_rf_rd", 32'(rf_rd), 32'd0);
    chk("rst_rf_wd", rf_wd, 32'd0);
    chk("rst_rs1_busy", 32'(rs1_busy), 32'd0);
    chk("rst_rs2_busy", 32'(rs2_busy), 32'd0);
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_alu_ready", 32'(alu_if.ready), 32'd0);
    chk("rst_lsu_ready", 32'(lsu_if.ready), 32'd0);
`ifdef RF_WB_BYPASS_EN
    chk("rst_fwd_val", 32'(rs1_fwd_val), 32'd0);
`endif
    advance();

    // arbitration table: expected readies follow LSU priority and ALU starvation after 3 denials
    vecs[0]  = mk(1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0);
    vecs[1]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0);
    vecs[3]  = mk(1'b1, 5'd3,  32'hA000_0003, 1'b1, 5'd4,  32'hB000_0004, 1'b0, 1'b1);
    vecs[4]  = mk(1'b1, 5'd3,  32'hA000_0003, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0);
    vecs[5]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h0000_0123, 1'b0, 1'b1);
    vecs[7]  = mk(1'b1, 5'd0,  32'h0000_0456, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0);
    vecs[8]  = mk(1'b1, 5'd10, 32'hA000_000A, 1'b1, 5'd11, 32'hB000_000B, 1'b0, 1'b1);
    vecs[9]  = mk(1'b1, 5'd10, 32'hA000_000A, 1'b1, 5'd12, 32'hB000_000C, 1'b0, 1'b1);
    vecs[10] = mk(1'b1, 5'd10, 32'hA000_000A, 1'b1, 5'd13, 32'hB000_000D, 1'b0, 1'b1);
    vecs[11] = mk(1'b1, 5'd10, 32'hA000_000A, 1'b1, 5'd14, 32'hB000_000E, 1'b1, 1'b0);
    vecs[12] = mk(1'b1, 5'd16, 32'hA000_0010, 1'b1, 5'd14, 32'hB000_000E, 1'b0, 1'b1);
    vecs[13] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd15, 32'hB000_000F, 1'b0, 1'b1);
    vecs[14] = mk(1'b1, 5'd16, 32'hA000_0010, 1'b1, 5'd17, 32'hB000_0011, 1'b0, 1'b1);
    vecs[15] = mk(1'b1, 5'd16, 32'hA000_0010, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0);
    vecs[16] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].awd, vecs[i].lv, vecs[i].lrd, vecs[i].lwd);
      settle();
      chk($sformatf("v%0d_alu_ready", i), 32'(alu_if.ready), 32'(vecs[i].e_ar));
      chk($sformatf("v%0d_lsu_ready", i), 32'(lsu_if.ready), 32'(vecs[i].e_lr));
      if (vecs[i].e_ar) push_exp(vecs[i].ard, vecs[i].awd);
      if (vecs[i].e_lr) push_exp(vecs[i].lrd, vecs[i].lwd);
      advance();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    settle();
    advance();

    // scoreboard: issue x7, write it back, set x8 on the clearing edge
    issue_valid = 1'b1; issue_rd = 5'd7;
    settle();
    chk("issue7_ready", 32'(issue_ready), 32'd1);
    advance();
    issue_valid = 1'b0; rs1 = 5'd7; rs2 = 5'd8;
    settle();
    chk("x7_busy", 32'(rs1_busy), 32'd1);
    chk("x8_idle", 32'(rs2_busy), 32'd0);
    chk("issue7_blocked", 32'(issue_ready), 32'd0);
    advance();
    drive(1'b1, 5'd7, 32'h7777_0007, 1'b0, 5'd0, 32'h0);
    settle();
    chk("wb7_alu_ready", 32'(alu_if.ready), 32'd1);
    chk("x7_busy_grant", 32'(rs1_busy), 32'd1);
    push_exp(5'd7, 32'h7777_0007);
    advance();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    issue_valid = 1'b1; issue_rd = 5'd8;
    settle();
    chk("issue8_ready", 32'(issue_ready), 32'd1);
`ifdef RF_WB_BYPASS_EN
    chk("x7_busy_fwd", 32'(rs1_busy), 32'd0);
    chk("x7_fwd_val", 32'(rs1_fwd_val), 32'd1);
    chk("x7_fwd_wd", rs1_fwd_wd, 32'h7777_0007);
    chk("x8_fwd_val", 32'(rs2_fwd_val), 32'd0);
`else
    chk("x7_busy_wecycle", 32'(rs1_busy), 32'd1);
`endif
    advance();
    issue_valid = 1'b0; issue_rd = 5'd7;
    settle();
    chk("x7_clear", 32'(rs1_busy), 32'd0);
    chk("x8_set", 32'(rs2_busy), 32'd1);
    chk("issue7_free", 32'(issue_ready), 32'd1);
    advance();

    // x0: issue always permitted, never busy
    issue_valid = 1'b1; issue_rd = 5'd0;
    settle();
    chk("issue0_ready", 32'(issue_ready), 32'd1);
    advance();
    issue_valid = 1'b0; rs1 = 5'd0;
    settle();
    chk("x0_busy", 32'(rs1_busy), 32'd0);
    chk("issue0_ready2", 32'(issue_ready), 32'd1);
    advance();

    // reset while x9 busy and a grant is taken at the reset edge
    issue_valid = 1'b1; issue_rd = 5'd9;
    settle();
    chk("issue9_ready", 32'(issue_ready), 32'd1);
    advance();
    issue_valid = 1'b0; rs1 = 5'd9; rs2 = 5'd8;
    drive(1'b1, 5'd9, 32'h9999_0009, 1'b0, 5'd0, 32'h0);
    settle();
    chk("x9_busy", 32'(rs1_busy), 32'd1);
    rst = 1'b1;
    advance();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    settle();
    chk("post_rst_x9", 32'(rs1_busy), 32'd0);
    chk("post_rst_x8", 32'(rs2_busy), 32'd0);
    chk("post_rst_issue9", 32'(issue_ready), 32'd1);
    advance();

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
